// File: rtl/axi_grid_w_tracker_if.sv
// AW/W bus bundle for axi_grid_w_tracker: SNI-side AW/W inputs and router-side W output.
// slave = tracker side, master = upstream SNI / downstream router side.
interface axi_grid_w_tracker_if #(
    parameter int GRID_ID_W = 4,
    parameter int DATA_W    = 64,
    parameter int LEN_W     = 8
);
    logic [GRID_ID_W-1:0] aw_dst_i;
    logic [LEN_W-1:0]     aw_len_i;
    logic                 aw_valid_i;
    logic                 aw_ready_o;
    logic [DATA_W-1:0]    w_data_i;
    logic [DATA_W/8-1:0]  w_strb_i;
    logic                 w_last_i;
    logic                 w_valid_i;
    logic                 w_ready_o;
    logic [DATA_W-1:0]    w_data_o;
    logic [DATA_W/8-1:0]  w_strb_o;
    logic                 w_last_o;
    logic [GRID_ID_W-1:0] w_dst_o;
    logic                 w_valid_o;
    logic                 w_ready_i;

    modport slave (
        input  aw_dst_i, aw_len_i, aw_valid_i,
        output aw_ready_o,
        input  w_data_i, w_strb_i, w_last_i, w_valid_i,
        output w_ready_o,
        output w_data_o, w_strb_o, w_last_o, w_dst_o, w_valid_o,
        input  w_ready_i
    );

    modport master (
        output aw_dst_i, aw_len_i, aw_valid_i,
        input  aw_ready_o,
        output w_data_i, w_strb_i, w_last_i, w_valid_i,
        input  w_ready_o,
        input  w_data_o, w_strb_o, w_last_o, w_dst_o, w_valid_o,
        output w_ready_i
    );
endinterface

// File: rtl/axi_grid_w_tracker.sv
// W-path destination tagger: AW descriptor FIFO, beat counter, regenerated WLAST, 1-stage W register.
// Define AXI_GRID_W_TRACKER_ERR_EN to include the upstream-WLAST mismatch checker (err_o).
module axi_grid_w_tracker #(
    parameter int GRID_ID_W = 4,
    parameter int DATA_W    = 64,
    parameter int LEN_W     = 8,
    parameter int DEPTH     = 4
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    axi_grid_w_tracker_if.slave     bus,
    output logic [$clog2(DEPTH):0]  pending_o,
    output logic                    err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = DATA_W / 8;

    logic [GRID_ID_W-1:0] dst_mem_q [DEPTH];
    logic [GRID_ID_W-1:0] dst_mem_d [DEPTH];
    logic [LEN_W-1:0]     len_mem_q [DEPTH];
    logic [LEN_W-1:0]     len_mem_d [DEPTH];

    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [PW-1:0]        count;
    logic [LEN_W-1:0]     beat_cnt_q, beat_cnt_d;

    logic                 vld_q, vld_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [SW-1:0]        strb_q, strb_d;
    logic                 last_q, last_d;
    logic [GRID_ID_W-1:0] dst_q, dst_d;

    logic                 full, empty;
    logic                 push, accept, is_last, w_ready;
    logic [LEN_W-1:0]     head_len;
    logic [GRID_ID_W-1:0] head_dst;

    // Extra pointer bit distinguishes full from empty when indices match
    assign count    = wptr_q - rptr_q;
    assign full     = (count == PW'(DEPTH));
    assign empty    = (count == '0);
    assign head_len = len_mem_q[rptr_q[AW-1:0]];
    assign head_dst = dst_mem_q[rptr_q[AW-1:0]];

    assign push     = bus.aw_valid_i && !full;
    assign w_ready  = !empty && (!vld_q || bus.w_ready_i);
    assign accept   = bus.w_valid_i && w_ready;
    assign is_last  = (beat_cnt_q == head_len);

    always_comb begin
        dst_mem_d  = dst_mem_q;
        len_mem_d  = len_mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        beat_cnt_d = beat_cnt_q;
        vld_d      = vld_q;
        data_d     = data_q;
        strb_d     = strb_q;
        last_d     = last_q;
        dst_d      = dst_q;
        if (push) begin
            dst_mem_d[wptr_q[AW-1:0]] = bus.aw_dst_i;
            len_mem_d[wptr_q[AW-1:0]] = bus.aw_len_i;
            wptr_d = wptr_q + PW'(1);
        end
        if (accept) begin
            vld_d  = 1'b1;
            data_d = bus.w_data_i;
            strb_d = bus.w_strb_i;
            last_d = is_last;
            dst_d  = head_dst;
            if (is_last) begin
                beat_cnt_d = '0;
                rptr_d     = rptr_q + PW'(1);
            end else begin
                beat_cnt_d = beat_cnt_q + LEN_W'(1);
            end
        end else if (bus.w_ready_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        dst_mem_q <= dst_mem_d;
        len_mem_q <= len_mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            beat_cnt_q <= '0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            strb_q     <= '0;
            last_q     <= 1'b0;
            dst_q      <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            beat_cnt_q <= beat_cnt_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
            last_q     <= last_d;
            dst_q      <= dst_d;
        end
    end

`ifdef AXI_GRID_W_TRACKER_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = accept && (bus.w_last_i != is_last);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_o = err_q;
`else
    logic unused_w_last;
    assign unused_w_last = bus.w_last_i;
    assign err_o         = 1'b0;
`endif

    assign bus.aw_ready_o = !full;
    assign bus.w_ready_o  = w_ready;
    assign bus.w_valid_o  = vld_q;
    assign bus.w_data_o   = data_q;
    assign bus.w_strb_o   = strb_q;
    assign bus.w_last_o   = last_q;
    assign bus.w_dst_o    = dst_q;
    assign pending_o      = count;
endmodule
